// File: rtl/mcs4_rom_chip.sv
// mcs4_rom_chip: i4001-style program ROM on the MCS-4 bus.
// Follows the 8-phase instruction cycle from SYNC_N. It returns the opcode
// nibbles in M1/M2 when the A3 nibble matches CHIP_ID.
// Optional I/O port (SRC select, WRR write, RDR read) is built only when the
// macro MCS4_ROM_IO_PORT_EN is defined. Without it, IO_O is tied to zero.
// The ROM image is supplied as a 256 x 8 parameter (entry n = byte at address n).
module mcs4_rom_chip #(
  parameter logic [3:0]          CHIP_ID   = 4'h0,
  parameter logic [255:0][7:0]   ROM_IMAGE = '0
) (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic       SYNC_N,
  input  logic [3:0] DATA_I,
  output logic [3:0] DATA_O,
  output logic       DATA_OE,
  input  logic       CM_ROM_N,
  input  logic [3:0] IO_I,
  output logic [3:0] IO_O,
  output logic [2:0] PHASE
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  phase_t      phase, phase_nxt;
  logic        synced;
  logic [7:0]  addr;
  logic        sel_f;
  logic [3:0]  opr, opa;
  logic [7:0]  rom_byte;
  logic        resync;
  logic        rdr_hit;

  assign PHASE    = phase;
  assign rom_byte = ROM_IMAGE[addr];
  // SYNC_N low anywhere except at the end of X3 means the CPU restarted mid-cycle.
  assign resync   = ~SYNC_N & (phase != PH_X3);

  // Phase register; reset parks it in X3 so the first SYNC_N lands on A1.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) phase <= PH_X3;
    else        phase <= phase_nxt;
  end

  // Next phase: SYNC_N forces A1, otherwise advance and free-run past X3.
  always_comb begin
    phase_nxt = PH_A1;
    if (SYNC_N) begin
      unique case (phase)
        PH_A1:   phase_nxt = PH_A2;
        PH_A2:   phase_nxt = PH_A3;
        PH_A3:   phase_nxt = PH_M1;
        PH_M1:   phase_nxt = PH_M2;
        PH_M2:   phase_nxt = PH_X1;
        PH_X1:   phase_nxt = PH_X2;
        PH_X2:   phase_nxt = PH_X3;
        PH_X3:   phase_nxt = PH_A1;
        default: phase_nxt = PH_A1;
      endcase
    end
  end

  // Fetch datapath and bus drive. Every action uses the bus value at the edge that ends the phase.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      synced  <= 1'b0;
      addr    <= '0;
      sel_f   <= 1'b0;
      opr     <= '0;
      opa     <= '0;
      DATA_O  <= '0;
      DATA_OE <= 1'b0;
    end else begin
      if (!SYNC_N) synced <= 1'b1;
      if (synced) begin
        if (resync) begin
          DATA_OE <= 1'b0;
          addr    <= '0;
          sel_f   <= 1'b0;
        end else begin
          unique case (phase)
            PH_A1: addr[3:0] <= DATA_I;
            PH_A2: addr[7:4] <= DATA_I;
            PH_A3: begin
              sel_f <= (DATA_I == CHIP_ID);
              if (DATA_I == CHIP_ID) begin
                DATA_OE <= 1'b1;
                DATA_O  <= rom_byte[7:4];
              end
            end
            PH_M1: begin
              opr <= DATA_I;
              if (sel_f) DATA_O <= rom_byte[3:0];
            end
            PH_M2: begin
              opa     <= DATA_I;
              DATA_OE <= 1'b0;
            end
            PH_X1: begin
              if (rdr_hit) begin
                DATA_O  <= IO_I;
                DATA_OE <= 1'b1;
              end
            end
            PH_X2: DATA_OE <= 1'b0;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef MCS4_ROM_IO_PORT_EN
  logic io_sel;
  logic io_cmd;
  logic wrr_hit;

  assign rdr_hit = io_cmd & io_sel & (opr == 4'hE) & (opa == 4'hA);
  assign wrr_hit = io_cmd & io_sel & (opr == 4'hE) & (opa == 4'h2);

  // I/O port state. SRC in X2 takes priority over WRR because both share the CM line.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      io_sel <= 1'b0;
      io_cmd <= 1'b0;
      IO_O   <= '0;
    end else if (synced) begin
      if (resync) begin
        io_cmd <= 1'b0;
      end else begin
        unique case (phase)
          PH_M2: io_cmd <= ~CM_ROM_N;
          PH_X2: begin
            if (!CM_ROM_N)    io_sel <= (DATA_I == CHIP_ID);
            else if (wrr_hit) IO_O   <= DATA_I;
          end
          PH_X3: io_cmd <= 1'b0;
          default: ;
        endcase
      end
    end
  end
`else
  logic unused_io;

  assign rdr_hit   = 1'b0;
  assign IO_O      = '0;
  assign unused_io = ^{CM_ROM_N, opr, opa};
`endif

endmodule

// File: tb/tb_mcs4_rom_chip.sv
// Self-checking bench for mcs4_rom_chip.
// The driver plays the CPU one instruction cycle at a time. For each bus phase
// it queues the response that a transaction-level ROM/IO model predicts.
// A monitor on the falling edge pops each queued response and compares it
// against the DUT outputs.
module tb_mcs4_rom_chip;

  localparam logic [3:0] CHIP = 4'h0;
`ifdef MCS4_ROM_IO_PORT_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  function automatic logic [7:0] img_byte(input int unsigned i);
    logic [7:0] v;
    v = 8'(i * 37 + 91) ^ 8'(i >> 3);
    if (i == 0) v = 8'hD5;
    return v;
  endfunction

  function automatic logic [255:0][7:0] make_img();
    logic [255:0][7:0] r;
    for (int unsigned i = 0; i < 256; i++) r[i] = img_byte(i);
    return r;
  endfunction

  localparam logic [255:0][7:0] IMG = make_img();

  logic       CLK = 1'b0;
  logic       RES_N = 1'b1;
  logic       SYNC_N = 1'b1;
  logic [3:0] DATA_I = '0;
  logic [3:0] DATA_O;
  logic       DATA_OE;
  logic       CM_ROM_N = 1'b1;
  logic [3:0] IO_I = '0;
  logic [3:0] IO_O;
  logic [2:0] PHASE;

  mcs4_rom_chip #(.CHIP_ID(CHIP), .ROM_IMAGE(IMG)) dut (
    .CLK(CLK), .RES_N(RES_N), .SYNC_N(SYNC_N), .DATA_I(DATA_I), .DATA_O(DATA_O),
    .DATA_OE(DATA_OE), .CM_ROM_N(CM_ROM_N), .IO_I(IO_I), .IO_O(IO_O), .PHASE(PHASE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] ph;
    logic       oe;
    logic [3:0] d;
    logic [3:0] io;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  // Model state kept at instruction-cycle level.
  logic       m_io_sel = 1'b0;
  logic [3:0] m_io_o = '0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Monitor: compare one queued expectation per bus phase.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("phase", {1'b0, PHASE}, {1'b0, mon_e.ph});
      check("data_oe", {3'b0, DATA_OE}, {3'b0, mon_e.oe});
      if (mon_e.oe) check("data_o", DATA_O, mon_e.d);
      check("io_o", IO_O, mon_e.io);
    end
  end

  // Called just after reset release inside the X3 interval: pull SYNC_N low once.
  task automatic sync_start();
    exp_t e;
    SYNC_N = 1'b0; DATA_I = '0; CM_ROM_N = 1'b1;
    e.ph = 3'd7; e.oe = 1'b0; e.d = '0; e.io = m_io_o;
    exp_q.push_back(e);
  endtask

  task automatic do_cycle(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                          input logic [3:0] op_r, input logic [3:0] op_a,
                          input logic cm_m2, input logic cm_x2, input logic [3:0] x2d,
                          input logic [3:0] io_in, input logic sync_x3,
                          input int resync_at, input int reset_at);
    logic [7:0] byte_v;
    logic       own, io_cmd_v, rdr;
    logic [3:0] opr_b, opa_b;
    exp_t       e;
    byte_v   = img_byte({24'b0, a2, a1});
    own      = (a3 == CHIP);
    opr_b    = own ? byte_v[7:4] : op_r;
    opa_b    = own ? byte_v[3:0] : op_a;
    io_cmd_v = !cm_m2;
    rdr      = IO_EN && io_cmd_v && m_io_sel && opr_b == 4'hE && opa_b == 4'hA;
    for (int ph = 0; ph < 8; ph++) begin
      @(posedge CLK); #1;
      case (ph)
        0: DATA_I = a1;
        1: DATA_I = a2;
        2: DATA_I = a3;
        3: DATA_I = opr_b;
        4: DATA_I = opa_b;
        6: DATA_I = x2d;
        default: DATA_I = '0;
      endcase
      CM_ROM_N = (ph == 4) ? cm_m2 : (ph == 6) ? cm_x2 : 1'b1;
      SYNC_N   = ((ph == 7 && sync_x3) || ph == resync_at) ? 1'b0 : 1'b1;
      IO_I     = io_in;
      e.ph = 3'(ph); e.oe = 1'b0; e.d = '0; e.io = m_io_o;
      if (own && ph == 3) begin e.oe = 1'b1; e.d = byte_v[7:4]; end
      if (own && ph == 4) begin e.oe = 1'b1; e.d = byte_v[3:0]; end
      if (rdr && ph == 6) begin e.oe = 1'b1; e.d = io_in; end
      exp_q.push_back(e);
      if (ph == resync_at) return;
      if (ph == reset_at) begin
        @(negedge CLK); #1;
        RES_N = 1'b0;
        #1;
        check("rst_data_oe", {3'b0, DATA_OE}, 4'h0);
        check("rst_data_o", DATA_O, 4'h0);
        check("rst_io_o", IO_O, 4'h0);
        check("rst_phase", {1'b0, PHASE}, 4'h7);
        m_io_sel = 1'b0;
        m_io_o   = '0;
        @(posedge CLK); #1;
        RES_N = 1'b1;
        sync_start();
        return;
      end
      if (ph == 6 && IO_EN) begin
        if (!cm_x2) m_io_sel = (x2d == CHIP);
        else if (io_cmd_v && m_io_sel && opr_b == 4'hE && opa_b == 4'h2) m_io_o = x2d;
      end
    end
  endtask

  task automatic rand_cycle();
    int unsigned k;
    logic [3:0] a3, opr_v, opa_v, x2d;
    logic cm_m2, cm_x2;
    k     = $urandom_range(0, 4);
    a3    = (k == 0 || $urandom_range(0, 3) == 0) ? CHIP : 4'($urandom);
    opr_v = (k >= 2) ? 4'hE : 4'($urandom);
    opa_v = (k == 2) ? 4'h2 : (k == 3) ? 4'hA : 4'($urandom);
    cm_m2 = (k >= 2) ? 1'b0 : 1'($urandom);
    cm_x2 = (k == 1) ? 1'b0 : 1'b1;
    x2d   = (k == 1 && $urandom_range(0, 1) == 1) ? CHIP : 4'($urandom);
    do_cycle(4'($urandom), 4'($urandom), a3, opr_v, opa_v, cm_m2, cm_x2, x2d,
             4'($urandom), 1'b1, 99, 99);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 RES_N = 1'b0;
    #1;
    check("reset_data_oe", {3'b0, DATA_OE}, 4'h0);
    check("reset_data_o", DATA_O, 4'h0);
    check("reset_io_o", IO_O, 4'h0);
    check("reset_phase", {1'b0, PHASE}, 4'h7);
    @(posedge CLK); @(posedge CLK); #1;
    RES_N = 1'b1;
    sync_start();

    // Own fetch of address 0 (D5), then a foreign fetch with A3 = 3.
    do_cycle(4'h0, 4'h0, CHIP, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 99, 99);
    do_cycle(4'h7, 4'h1, 4'h3, 4'h1, 4'h4, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 99, 99);
    // SRC to this chip, then WRR 9.
    do_cycle(4'h0, 4'h2, 4'h3, 4'h2, 4'h1, 1'b1, 1'b0, CHIP, 4'h0, 1'b1, 99, 99);
    do_cycle(4'h1, 4'h2, 4'h3, 4'hE, 4'h2, 1'b0, 1'b1, 4'h9, 4'h0, 1'b1, 99, 99);
    // SRC elsewhere: WRR 6 ignored, RDR not answered.
    do_cycle(4'h2, 4'h2, 4'h3, 4'h2, 4'h1, 1'b1, 1'b0, 4'h5, 4'h0, 1'b1, 99, 99);
    do_cycle(4'h3, 4'h2, 4'h3, 4'hE, 4'h2, 1'b0, 1'b1, 4'h6, 4'h0, 1'b1, 99, 99);
    do_cycle(4'h4, 4'h2, 4'h3, 4'hE, 4'hA, 1'b0, 1'b1, 4'h0, 4'hC, 1'b1, 99, 99);
    // Re-select and RDR with IO_I = C; this cycle ends without SYNC_N (free-run wrap).
    do_cycle(4'h5, 4'h2, 4'h3, 4'h2, 4'h1, 1'b1, 1'b0, CHIP, 4'h0, 1'b1, 99, 99);
    do_cycle(4'h6, 4'h2, 4'h3, 4'hE, 4'hA, 1'b0, 1'b1, 4'h0, 4'hC, 1'b0, 99, 99);
    do_cycle(4'hF, 4'hF, CHIP, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 99, 99);

    for (int n = 0; n < 150; n++) rand_cycle();

    // Resync during M1 of an own fetch, then a normal own fetch.
    do_cycle(4'h4, 4'h3, CHIP, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 3, 99);
    do_cycle(4'h8, 4'h9, CHIP, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 99, 99);
    // Load IO_O with A, then assert reset during M2 of an own fetch.
    do_cycle(4'h0, 4'h2, 4'h3, 4'h2, 4'h1, 1'b1, 1'b0, CHIP, 4'h0, 1'b1, 99, 99);
    do_cycle(4'h1, 4'h2, 4'h3, 4'hE, 4'h2, 1'b0, 1'b1, 4'hA, 4'h0, 1'b1, 99, 99);
    do_cycle(4'h2, 4'h0, CHIP, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 99, 4);

    for (int n = 0; n < 20; n++) rand_cycle();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
